// File: rtl/elastic_register_chain.sv
// elastic_register_chain: DEPTH-stage valid/ready register pipeline with
// bubble-collapsing backpressure, synchronous flush and occupancy count.
module elastic_register_chain #(
  parameter  int N     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] occupancy
);

  logic [DEPTH-1:0] valid;
  logic [N-1:0]     data     [DEPTH];
  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] up_valid;
  logic [N-1:0]     up_data  [DEPTH];

  // Ready chain: a stage may load when it is empty or the stage after it moves.
  // Built with a running accumulator from the output end so r has no self-loop.
  always_comb begin : ready_chain
    logic acc;
    r        = '0;
    r[DEPTH] = out_ready;
    acc      = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      acc              = ~valid[DEPTH-1-k] | acc;
      r[DEPTH-1-k]     = acc;
    end
  end

  // Upstream source of each stage: the input port for stage 0, else the previous stage.
  always_comb begin
    up_valid    = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      up_valid[k] = valid[k-1];
      up_data[k]  = data[k-1];
    end
  end

  // Stage registers: reset/flush zero everything, otherwise advance where ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) data[k] <= '0;
    end else if (clear) begin
      valid <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) data[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (r[k]) begin
          valid[k] <= up_valid[k];
          if (up_valid[k]) data[k] <= up_data[k];
        end
      end
    end
  end

  // Occupancy is the popcount of the stage valid flags.
  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occupancy = occupancy + CW'(valid[k]);
  end

  // rst gates in_ready because an empty chain in reset would otherwise look ready.
  assign in_ready  = r[0] & ~clear & rst;
  assign out_valid = valid[DEPTH-1] & ~clear;
  assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_elastic_register_chain.sv
// Self-checking bench for elastic_register_chain (N=8, DEPTH=4).
module tb_elastic_register_chain;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [N-1:0] sb [$];

  elastic_register_chain #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL latency_accept got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (k == DEPTH)) begin
        n_err++; $display("FAIL latency_out_valid cycle %0d got %0b want %0b", k, out_valid, (k == DEPTH));
      end
      if (k == DEPTH) begin
        n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL latency_out_data got %h want 11", out_data); end
      end
    end
    @(negedge clk);
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL latency_drained got %0d want 0", occupancy); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept beat %0d got %0b want 1", k, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_full_occupancy got %0d want 4", occupancy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready got %0b want 0", in_ready); end
      n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL bp_full_out_data got %h want 01", out_data); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain_gap beat %0d got %0b want 1", k, out_valid); end
      n_cmp++; if (out_data !== 8'(k)) begin n_err++; $display("FAIL bp_drain_data got %h want %h", out_data, 8'(k)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bp_drained got %0d want 0", occupancy); end
  endtask

  task automatic test_gapped_stall();
    int unsigned waited;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'h21 + 8'(i / 2);
      @(negedge clk);
      if (in_valid) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_accept step %0d got %0b want 1", i, in_ready); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL gap_occupancy got %0d want 4", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL gap_full_in_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waited = 0;
    while (occupancy != 0 && waited < 20) begin @(posedge clk); #1; waited++; end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL gap_drain_timeout got %0d want 0", occupancy); end
  endtask

  task automatic test_streaming();
    int unsigned waited;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'h40 + 8'(k);
      @(negedge clk);
      n_cmp++;
      if (occupancy !== CW'((k < 4) ? k : 4)) begin
        n_err++; $display("FAIL stream_occupancy cycle %0d got %0d want %0d", k, occupancy, (k < 4) ? k : 4);
      end
      if (k >= 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out_valid cycle %0d got %0b want 1", k, out_valid); end
        n_cmp++;
        if (out_data !== 8'h40 + 8'(k - 4)) begin
          n_err++; $display("FAIL stream_out_data cycle %0d got %h want %h", k, out_data, 8'h40 + 8'(k - 4));
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0;
    waited = 0;
    while (occupancy != 0 && waited < 20) begin @(posedge clk); #1; waited++; end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL stream_drain_timeout got %0d want 0", occupancy); end
  endtask

  task automatic test_clear();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(k);
      @(posedge clk); #1;
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clear_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_out_valid got %0b want 0", out_valid); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL clear_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL clear_out_data got %h want 00", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL clear_after_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_after_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h34 + 8'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL midrst_out_data got %h want 00", out_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL midrst_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_release_out_valid got %0b want 0", out_valid); end
  endtask

  initial begin
    fork
      begin : scoreboard
        logic [N-1:0] exp_data;
        forever begin
          @(negedge clk);
          if (!rst || clear) begin
            sb.delete();
          end else begin
            if (out_valid && out_ready) begin
              n_cmp++;
              if (sb.size() == 0) begin
                n_err++; $display("FAIL sb_unexpected_output got %h want no beat", out_data);
              end else begin
                exp_data = sb.pop_front();
                if (out_data !== exp_data) begin
                  n_err++; $display("FAIL sb_order got %h want %h", out_data, exp_data);
                end
              end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
          end
        end
      end
      begin : tests
        test_reset();
        test_latency();
        test_backpressure();
        test_gapped_stall();
        test_streaming();
        test_clear();
        test_reset_midstream();
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d beats want 0", sb.size()); end
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
